// File: rtl/vec_strided_lsu_if.sv
// ---------------------------------------------------------------------------
// vec_strided_lsu_if
// Memory-port bundle between the strided load/store sequencer and the
// coprocessor memory port.
//
// Handshake: the master raises mem_valid with mem_addr/mem_wdata/mem_wstrb
// and holds all of them stable until it samples mem_ready high on a rising
// clock edge; that edge is the transfer. mem_rdata is only meaningful in the
// cycle where mem_ready is high. The master never drops mem_valid before the
// transfer, and never presents two requests on consecutive cycles.
//
// Signals:
//   mem_valid  master -> slave  request valid
//   mem_ready  slave  -> master request accepted / read data valid
//   mem_addr   master -> slave  word-aligned byte address
//   mem_wdata  master -> slave  lane-replicated store data
//   mem_wstrb  master -> slave  byte strobes (0 on loads)
//   mem_rdata  slave  -> master load data
// ---------------------------------------------------------------------------
interface vec_strided_lsu_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/vec_strided_lsu.sv
// ---------------------------------------------------------------------------
// vec_strided_lsu
// Strided load/store sequencer for vlse.v / vsse.v. Issues one memory
// transaction per element at base + i*stride (i = 0..vl-1), extracts the
// SEW-sized lane on loads into the VRF, and builds lane-aligned write data
// and byte strobes on stores.
//
// Optional feature macro: VEC_LSU_PERF_EN (memory stall-cycle counter).
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   start              one-cycle request, sampled only in IDLE
//   is_store           1 = store, 0 = load
//   base, stride       byte base address and signed byte stride
//   vl                 element count (clamped to MAX_VL)
//   sew                00 = 8b, 01 = 16b, 10 = 32b, 11 = reserved (error)
//   busy, done, error  status; done/error are one-cycle pulses
//   mem                memory port (vec_strided_lsu_if.master)
//   elem_wr_*          VRF write port for loaded elements
//   elem_rd_idx/data   VRF read port for store elements (combinational read)
//   perf_stall_cycles  cycles with mem_valid && !mem_ready (0 when disabled)
//   dbg_state          current FSM state encoding
// ---------------------------------------------------------------------------
module vec_strided_lsu #(
  parameter int MAX_VL = 32,
  parameter int VL_W   = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             is_store,
  input  logic [31:0]      base,
  input  logic [31:0]      stride,
  input  logic [VL_W-1:0]  vl,
  input  logic [1:0]       sew,
  output logic             busy,
  output logic             done,
  output logic             error,
  vec_strided_lsu_if.master mem,
  output logic             elem_wr_en,
  output logic [VL_W-1:0]  elem_wr_idx,
  output logic [31:0]      elem_wr_data,
  output logic [VL_W-1:0]  elem_rd_idx,
  input  logic [31:0]      elem_rd_data,
  output logic [31:0]      perf_stall_cycles,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_REQ   = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t          state;
  logic            store_q;
  logic [31:0]     stride_q;
  logic [31:0]     ea;
  logic [VL_W-1:0] vl_q;
  logic [VL_W-1:0] idx;
  logic [1:0]      sew_q;

  logic            mem_valid_q;
  logic [31:0]     mem_addr_q;
  logic [31:0]     mem_wdata_q;
  logic [3:0]      mem_wstrb_q;

  logic            aligned;
  logic [3:0]      lane_strb;
  logic [31:0]     lane_wdata;
  logic [31:0]     lane_rdata;
  logic [31:0]     rdata_shifted;
  logic [VL_W-1:0] vl_clamped;
  logic            last_elem;

  assign vl_clamped = (vl > VL_W'(MAX_VL)) ? VL_W'(MAX_VL) : vl;
  assign last_elem  = (idx == (vl_q - VL_W'(1)));

  // Lane steering, all keyed on the byte offset ea[1:0] of the current element.
  always_comb begin
    aligned       = 1'b0;
    lane_strb     = 4'b0000;
    lane_wdata    = 32'h0;
    lane_rdata    = 32'h0;
    rdata_shifted = mem.mem_rdata >> {ea[1:0], 3'b000};
    case (sew_q)
      2'b00: begin
        aligned    = 1'b1;
        lane_strb  = 4'b0001 << ea[1:0];
        lane_wdata = {4{elem_rd_data[7:0]}};
        lane_rdata = {24'h0, rdata_shifted[7:0]};
      end
      2'b01: begin
        aligned    = ~ea[0];
        lane_strb  = 4'b0011 << ea[1:0];
        lane_wdata = {2{elem_rd_data[15:0]}};
        lane_rdata = {16'h0, rdata_shifted[15:0]};
      end
      2'b10: begin
        aligned    = (ea[1:0] == 2'b00);
        lane_strb  = 4'b1111;
        lane_wdata = elem_rd_data;
        lane_rdata = mem.mem_rdata;
      end
      default: begin
        aligned = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      store_q      <= 1'b0;
      stride_q     <= 32'h0;
      ea           <= 32'h0;
      vl_q         <= '0;
      idx          <= '0;
      sew_q        <= 2'b00;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_wstrb_q  <= 4'b0000;
      elem_wr_en   <= 1'b0;
      elem_wr_idx  <= '0;
      elem_wr_data <= 32'h0;
    end else begin
      done       <= 1'b0;
      error      <= 1'b0;
      elem_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            store_q  <= is_store;
            stride_q <= stride;
            vl_q     <= vl_clamped;
            sew_q    <= sew;
            ea       <= base;
            idx      <= '0;
            busy     <= 1'b1;
            if (sew == 2'b11) begin
              state <= S_ERR;
              error <= 1'b1;
            end else if (vl == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_CHECK;
            end
          end
        end
        // The VRF read for a store settles during CHECK (elem_rd_idx = idx),
        // so the write data is latched here and held through REQ.
        S_CHECK: begin
          if (!aligned) begin
            state <= S_ERR;
            error <= 1'b1;
          end else begin
            state       <= S_REQ;
            mem_valid_q <= 1'b1;
            mem_addr_q  <= {ea[31:2], 2'b00};
            mem_wstrb_q <= store_q ? lane_strb  : 4'b0000;
            mem_wdata_q <= store_q ? lane_wdata : 32'h0;
          end
        end
        S_REQ: begin
          if (mem.mem_ready) begin
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= 32'h0;
            if (!store_q) begin
              elem_wr_en   <= 1'b1;
              elem_wr_idx  <= idx;
              elem_wr_data <= lane_rdata;
            end
            idx <= idx + VL_W'(1);
            ea  <= ea + stride_q;
            if (last_elem) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_CHECK;
            end
          end
        end
        S_DONE, S_ERR: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef VEC_LSU_PERF_EN
  // Stall counter: cleared by an accepted start, saturating, held after finish.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_stall_cycles <= 32'h0;
    end else if (state == S_IDLE && start) begin
      perf_stall_cycles <= 32'h0;
    end else if (mem_valid_q && !mem.mem_ready && perf_stall_cycles != 32'hFFFF_FFFF) begin
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`else
  assign perf_stall_cycles = 32'h0;
`endif

  assign mem.mem_valid = mem_valid_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_wstrb = mem_wstrb_q;
  assign elem_rd_idx   = idx;
  assign dbg_state     = state;

endmodule

// File: tb/tb_vec_strided_lsu.sv
// ---------------------------------------------------------------------------
// tb_vec_strided_lsu
// Directed bench for vec_strided_lsu: a word-addressed memory responder with
// programmable wait states, a VRF model, negedge monitors, and one linear
// sequence of hand-computed checks.
// ---------------------------------------------------------------------------
module tb_vec_strided_lsu;
  localparam int VL_W = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic            start, is_store;
  logic [31:0]     base, stride;
  logic [VL_W-1:0] vl;
  logic [1:0]      sew;
  logic            busy, done, error;
  logic            elem_wr_en;
  logic [VL_W-1:0] elem_wr_idx, elem_rd_idx;
  logic [31:0]     elem_wr_data, elem_rd_data;
  logic [31:0]     perf_stall_cycles;
  logic [2:0]      dbg_state;

  vec_strided_lsu_if bus ();

  vec_strided_lsu #(.MAX_VL(32), .VL_W(VL_W)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .start             (start),
    .is_store          (is_store),
    .base              (base),
    .stride            (stride),
    .vl                (vl),
    .sew               (sew),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .mem               (bus),
    .elem_wr_en        (elem_wr_en),
    .elem_wr_idx       (elem_wr_idx),
    .elem_wr_data      (elem_wr_data),
    .elem_rd_idx       (elem_rd_idx),
    .elem_rd_data      (elem_rd_data),
    .perf_stall_cycles (perf_stall_cycles),
    .dbg_state         (dbg_state)
  );

  // ---------------- VRF model ----------------
  logic [31:0] vrf [0:31];
  assign elem_rd_data = vrf[elem_rd_idx[4:0]];

  // ---------------- memory responder ----------------
  logic [31:0] mem_words [0:1023];
  logic [31:0] addr_q[$], strb_q[$], wdata_q[$];
  int          wait_cycles;

  initial begin
    int          wait_cnt;
    logic [9:0]  widx;
    wait_cnt = 0;
    for (int k = 0; k < 1024; k++) mem_words[k] = 32'h0;
    mem_words[100] = 32'h04030201; mem_words[101] = 32'h08070605;
    mem_words[102] = 32'h0c0b0a09; mem_words[103] = 32'h000f0e0d;
    mem_words[104] = 32'h14131211; mem_words[105] = 32'h18171615;
    mem_words[106] = 32'h1c1b1a19; mem_words[107] = 32'h101f1e1d;
    mem_words[0]   = 32'hA0A0A0A0; mem_words[1]   = 32'hB1B1B1B1;
    mem_words[2]   = 32'hC2C2C2C2; mem_words[1023] = 32'hDEADBEEF;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.mem_valid && !bus.mem_ready) begin
        if (wait_cnt >= wait_cycles) begin
          widx = bus.mem_addr[11:2];
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem_words[widx];
          for (int b = 0; b < 4; b++)
            if (bus.mem_wstrb[b]) mem_words[widx][8*b +: 8] = bus.mem_wdata[8*b +: 8];
          addr_q.push_back(bus.mem_addr);
          strb_q.push_back({28'h0, bus.mem_wstrb});
          wdata_q.push_back(bus.mem_wdata);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        bus.mem_ready = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // ---------------- output monitor ----------------
  logic [31:0] wr_idx_q[$], wr_data_q[$];
  int          done_cnt = 0, err_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (elem_wr_en) begin
        wr_idx_q.push_back({26'h0, elem_wr_idx});
        wr_data_q.push_back(elem_wr_data);
      end
      if (done)  done_cnt++;
      if (error) err_cnt++;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_vec = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  int          m_addr, m_wr, m_done, m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    m_addr = addr_q.size();
    m_wr   = wr_idx_q.size();
    m_done = done_cnt;
    m_err  = err_cnt;
  endtask

  function automatic int obs_size(input int which);
    if (which <= 2) return addr_q.size() - m_addr;
    return wr_idx_q.size() - m_wr;
  endfunction

  function automatic logic [31:0] obs_at(input int which, input int k);
    case (which)
      0:       return addr_q[m_addr + k];
      1:       return strb_q[m_addr + k];
      2:       return wdata_q[m_addr + k];
      3:       return wr_idx_q[m_wr + k];
      default: return wr_data_q[m_wr + k];
    endcase
  endfunction

  // which: 0 addr, 1 strb, 2 wdata, 3 wr_idx, 4 wr_data
  task automatic check_stream(input string tag, input int which);
    int n;
    n = obs_size(which);
    check({tag, "_count"}, 32'(n), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < n; k++)
      check($sformatf("%s[%0d]", tag, k), obs_at(which, k), exp_q[k]);
    exp_q.delete();
  endtask

  task automatic check_flags(input string tag, input int exp_done, input int exp_err);
    check({tag, "_done"},  32'(done_cnt - m_done), 32'(exp_done));
    check({tag, "_error"}, 32'(err_cnt - m_err),   32'(exp_err));
  endtask

  // ---------------- driver tasks ----------------
  task automatic launch(input logic st, input logic [31:0] b, input logic [31:0] s,
                        input logic [VL_W-1:0] n, input logic [1:0] w);
    is_store = st; base = b; stride = s; vl = n; sew = w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag, output int cyc);
    cyc = 1;
    while (!(done || error) && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_finished"}, 32'(cyc < 600), 32'd1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run(input string tag, input logic st, input logic [31:0] b,
                     input logic [31:0] s, input logic [VL_W-1:0] n, input logic [1:0] w);
    int cyc;
    mark();
    launch(st, b, s, n, w);
    wait_end(tag, cyc);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int  exp_perf;
    wait_cycles = 0;
    resetn = 1'b0; start = 1'b0; is_store = 1'b0;
    base = 32'h0; stride = 32'h0; vl = '0; sew = 2'b00;
    for (int k = 0; k < 32; k++) vrf[k] = 32'h0;
    m_addr = 0; m_wr = 0; m_done = 0; m_err = 0;
    repeat (3) @(negedge clk);
    check("reset_status", {29'h0, busy, done, error}, 32'h0);
    check("reset_mem", {31'h0, bus.mem_valid}, 32'h0);
    check("reset_misc", {perf_stall_cycles[28:0], dbg_state}, 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // sew32 strided load
    run("ld32", 1'b0, 32'd400, 32'd8, 6'd4, 2'b10);
    exp_q = '{32'd400, 32'd408, 32'd416, 32'd424};             check_stream("ld32_addr", 0);
    exp_q = '{32'h0, 32'h0, 32'h0, 32'h0};                     check_stream("ld32_strb", 1);
    exp_q = '{32'd0, 32'd1, 32'd2, 32'd3};                     check_stream("ld32_idx", 3);
    exp_q = '{32'h04030201, 32'h0c0b0a09, 32'h14131211, 32'h1c1b1a19};
    check_stream("ld32_data", 4);
    check_flags("ld32", 1, 0);
    check("ld32_idle", {29'h0, dbg_state}, 32'h0);

    // sew32 strided store
    vrf[0] = 32'hAAAA0001; vrf[1] = 32'hBBBB0002;
    run("st32", 1'b1, 32'd600, 32'd8, 6'd2, 2'b10);
    exp_q = '{32'd600, 32'd608};                               check_stream("st32_addr", 0);
    exp_q = '{32'hF, 32'hF};                                   check_stream("st32_strb", 1);
    exp_q = '{32'hAAAA0001, 32'hBBBB0002};                     check_stream("st32_wdata", 2);
    check("st32_no_vrf_write", 32'(obs_size(3)), 32'd0);
    check("st32_mem150", mem_words[150], 32'hAAAA0001);
    check_flags("st32", 1, 0);

    // sew8 byte load, unit stride inside one word
    run("ld8", 1'b0, 32'd401, 32'd1, 6'd3, 2'b00);
    exp_q = '{32'd400, 32'd400, 32'd400};                      check_stream("ld8_addr", 0);
    exp_q = '{32'h02, 32'h03, 32'h04};                         check_stream("ld8_data", 4);

    // start while busy is ignored (slow memory keeps the op in flight)
    wait_cycles = 3;
    mark();
    launch(1'b0, 32'd400, 32'd8, 6'd2, 2'b10);
    check("busy_after_start", {31'h0, busy}, 32'h1);
    is_store = 1'b1; base = 32'h0; vl = 6'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end("busy_start", cyc);
    exp_q = '{32'd400, 32'd408};                               check_stream("busy_start_addr", 0);
    exp_q = '{32'h04030201, 32'h0c0b0a09};                     check_stream("busy_start_data", 4);
    check_flags("busy_start", 1, 0);
    check("busy_low_after", {31'h0, busy}, 32'h0);
    wait_cycles = 0;

    // sew8 byte store at offset 1
    vrf[0] = 32'h0000005A;
    run("st8", 1'b1, 32'd401, 32'd4, 6'd1, 2'b00);
    exp_q = '{32'd400};                                        check_stream("st8_addr", 0);
    exp_q = '{32'b0010};                                       check_stream("st8_strb", 1);
    exp_q = '{32'h5A5A5A5A};                                   check_stream("st8_wdata", 2);
    check("st8_mem100", mem_words[100], 32'h04035A01);

    // sew16: first element aligned, second misaligned -> error, first kept
    run("ld16_mis", 1'b0, 32'd400, 32'd1, 6'd3, 2'b01);
    exp_q = '{32'd400};                                        check_stream("ld16_mis_addr", 0);
    exp_q = '{32'h00005A01};                                   check_stream("ld16_mis_data", 4);
    check_flags("ld16_mis", 0, 1);

    // vl = 0: done on the first cycle, no memory traffic
    mark();
    launch(1'b0, 32'd400, 32'd8, 6'd0, 2'b10);
    wait_end("vl0", cyc);
    check("vl0_latency", 32'(cyc), 32'd1);
    check("vl0_no_req", 32'(obs_size(0)), 32'd0);
    check_flags("vl0", 1, 0);

    // sew32 misaligned base
    run("mis32", 1'b0, 32'd402, 32'd4, 6'd2, 2'b10);
    check("mis32_no_req", 32'(obs_size(0)), 32'd0);
    check_flags("mis32", 0, 1);

    // reserved sew
    run("sew11", 1'b0, 32'd400, 32'd4, 6'd2, 2'b11);
    check("sew11_no_req", 32'(obs_size(0)), 32'd0);
    check_flags("sew11", 0, 1);

    // negative stride
    run("neg", 1'b0, 32'd8, 32'hFFFF_FFFC, 6'd3, 2'b10);
    exp_q = '{32'd8, 32'd4, 32'd0};                            check_stream("neg_addr", 0);
    exp_q = '{32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};       check_stream("neg_data", 4);

    // address wrap
    run("wrap", 1'b0, 32'hFFFF_FFFC, 32'd4, 6'd2, 2'b10);
    exp_q = '{32'hFFFF_FFFC, 32'h0000_0000};                   check_stream("wrap_addr", 0);
    exp_q = '{32'hDEADBEEF, 32'hA0A0A0A0};                     check_stream("wrap_data", 4);

    // vl above MAX_VL clamps to 32, stride 0 hits one address
    run("clamp", 1'b0, 32'd400, 32'd0, 6'd40, 2'b10);
    check("clamp_req_count", 32'(obs_size(0)), 32'd32);
    check("clamp_wr_count", 32'(obs_size(3)), 32'd32);
    check("clamp_last_idx", (wr_idx_q.size() > 0) ? wr_idx_q[wr_idx_q.size()-1] : 32'hFFFF_FFFF, 32'd31);
    check("clamp_last_addr", (addr_q.size() > 0) ? addr_q[addr_q.size()-1] : 32'hFFFF_FFFF, 32'd400);

    // asynchronous reset while a request is outstanding
    wait_cycles = 20;
    mark();
    launch(1'b0, 32'd400, 32'd8, 6'd4, 2'b10);
    cyc = 0;
    while (!bus.mem_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_req_seen", {31'h0, bus.mem_valid}, 32'h1);
    resetn = 1'b0;
    #1;
    check("rst_status", {28'h0, busy, done, error, elem_wr_en}, 32'h0);
    check("rst_mem_valid", {31'h0, bus.mem_valid}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_state", {29'h0, dbg_state}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_idle_after", {29'h0, dbg_state}, 32'h0);
    check("rst_no_req", 32'(obs_size(0)), 32'd0);
    check("rst_no_wr", 32'(obs_size(3)), 32'd0);
    check_flags("rst", 0, 0);

    // stall counter with two wait states per access
    wait_cycles = 2;
`ifdef VEC_LSU_PERF_EN
    exp_perf = 8;
`else
    exp_perf = 0;
`endif
    run("perf", 1'b0, 32'd400, 32'd8, 6'd4, 2'b10);
    exp_q = '{32'h04035A01, 32'h0c0b0a09, 32'h14131211, 32'h1c1b1a19};
    check_stream("perf_data", 4);
    check("perf_stalls", perf_stall_cycles, 32'(exp_perf));
    repeat (3) @(negedge clk);
    check("perf_hold", perf_stall_cycles, 32'(exp_perf));
    wait_cycles = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
